// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 8-bit-instruction core:
// opcode map, instruction formats and sequencer state encoding.
package isa_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLL  = 4'h4;
  localparam logic [3:0] OP_SRL  = 4'h5;
  localparam logic [3:0] OP_LIM  = 4'h6;
  localparam logic [3:0] OP_LB   = 4'h7;
  localparam logic [3:0] OP_LHB  = 4'h8;
  localparam logic [3:0] OP_STR  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'ha;
  localparam logic [3:0] OP_BEQ  = 4'hb;
  localparam logic [3:0] OP_BNE  = 4'hc;
  localparam logic [3:0] OP_BLT  = 4'hd;
  localparam logic [3:0] OP_HALT = 4'he;
  localparam logic [3:0] OP_TBA  = 4'hf;

  typedef enum logic [1:0] {
    FMT_C,
    FMT_I,
    FMT_M,
    FMT_X
  } fmt_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT_MEM,
    S_HALT
  } seq_state_t;

  function automatic fmt_t fmt_of(input logic [3:0] op);
    fmt_t f;
    case (op)
      OP_ADD, OP_SUB, OP_AND,
      OP_OR, OP_SLL, OP_SRL:   f = FMT_C;
      OP_LIM:                  f = FMT_I;
      OP_LB, OP_LHB, OP_STR:   f = FMT_M;
      default:                 f = FMT_X;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational opcode classifier: branch decision plus
// memory / halt / illegal flags for the sequencer.
module branch_resolve
  import isa_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       eq_flag,
  input  logic       lt_flag,
  output logic       taken,
  output logic       is_mem,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      (opcode == OP_JMP): taken = 1'b1;
      (opcode == OP_BEQ): taken = eq_flag;
      (opcode == OP_BNE): taken = ~eq_flag;
      (opcode == OP_BLT): taken = lt_flag;
      default:            taken = 1'b0;
    endcase
  end

  assign is_mem     = (fmt_of(opcode) == FMT_M);
  assign is_halt    = (opcode == OP_HALT);
  assign is_illegal = (opcode == OP_TBA);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: fetch sequencing, branches,
// memory stalls, HALT/fault handling and saturating counters.
module pc_sequencer
  import isa_pkg::*;
#(
  parameter int unsigned PC_W      = 16,
  parameter int unsigned ROM_DEPTH = 128,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  init_pc,
  input  logic [3:0]       opcode,
  input  logic [PC_W-1:0]  jmp_loc,
  input  logic             eq_flag,
  input  logic             lt_flag,
  input  logic             mem_busy,
  output logic [PC_W-1:0]  pc,
  output logic             exec_en,
  output logic             halted,
  output logic             done,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [PC_W:0] DEPTH = (PC_W+1)'(ROM_DEPTH);

  seq_state_t       state_q;
  seq_state_t       state_d;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_d;
  logic             fault_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instr_q;

  logic taken;
  logic is_mem;
  logic is_halt;
  logic is_illegal;

  logic retire;
  logic fault_set;
  logic clr;
  logic busy_state;

  // one extra bit so a wrap past all-ones still reads as overflow
  logic [PC_W:0] inc;
  logic [PC_W:0] nxt_run;
  logic          ovf_inc;
  logic          ovf_run;

  branch_resolve u_br (
    .opcode     (opcode),
    .eq_flag    (eq_flag),
    .lt_flag    (lt_flag),
    .taken      (taken),
    .is_mem     (is_mem),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  assign inc     = {1'b0, pc_q} + (PC_W+1)'(1);
  assign nxt_run = taken ? {1'b0, jmp_loc} : inc;
  assign ovf_inc = (inc >= DEPTH);
  assign ovf_run = (nxt_run >= DEPTH);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    exec_en   = 1'b0;
    done      = 1'b0;
    retire    = 1'b0;
    fault_set = 1'b0;
    clr       = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = init_pc;
          clr     = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        unique case (1'b1)
          is_illegal: begin
            fault_set = 1'b1;
            state_d   = S_HALT;
          end
          is_halt: begin
            exec_en = 1'b1;
            retire  = 1'b1;
            done    = 1'b1;
            state_d = S_HALT;
          end
          (is_mem && mem_busy): begin
            state_d = S_WAIT_MEM;
          end
          default: begin
            exec_en = 1'b1;
            retire  = 1'b1;
            if (ovf_run) begin
              fault_set = 1'b1;
              state_d   = S_HALT;
            end else begin
              pc_d = nxt_run[PC_W-1:0];
            end
          end
        endcase
      end
      S_WAIT_MEM: begin
        if (!mem_busy) begin
          exec_en = 1'b1;
          retire  = 1'b1;
          if (ovf_inc) begin
            fault_set = 1'b1;
            state_d   = S_HALT;
          end else begin
            pc_d    = inc[PC_W-1:0];
            state_d = S_RUN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_state = (state_q == S_RUN) ||
                      (state_q == S_WAIT_MEM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (clr) begin
      fault_q <= 1'b0;
    end else if (fault_set) begin
      fault_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else if (clr) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if (busy_state && (cycle_q != '1)) begin
        cycle_q <= cycle_q + CNT_W'(1);
      end
      if (retire && (instr_q != '1)) begin
        instr_q <= instr_q + CNT_W'(1);
      end
    end
  end

  assign pc        = pc_q;
  assign halted    = (state_q == S_HALT);
  assign fault     = fault_q;
  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; the bench acts as the
// instruction ROM and checks hand-computed sequences.
module tb_pc_sequencer;
  import isa_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] init_pc;
  logic [3:0]  opcode;
  logic [15:0] jmp_loc;
  logic        eq_flag;
  logic        lt_flag;
  logic        mem_busy;
  logic [15:0] pc;
  logic        exec_en, halted, done, fault;
  logic [15:0] cycle_cnt, instr_cnt;
  logic [15:0] pc4;
  logic        exec_en4, halted4, done4, fault4;
  logic [3:0]  cycle4, instr4;

  logic [3:0]  rom_op [0:127];
  logic [15:0] rom_jl [0:127];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign opcode  = (pc < 16'd128) ? rom_op[pc[6:0]] : OP_TBA;
  assign jmp_loc = (pc < 16'd128) ? rom_jl[pc[6:0]] : 16'd0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .init_pc(init_pc), .opcode(opcode), .jmp_loc(jmp_loc),
    .eq_flag(eq_flag), .lt_flag(lt_flag), .mem_busy(mem_busy),
    .pc(pc), .exec_en(exec_en), .halted(halted), .done(done),
    .fault(fault), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  pc_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start),
    .init_pc(init_pc), .opcode(opcode), .jmp_loc(jmp_loc),
    .eq_flag(eq_flag), .lt_flag(lt_flag), .mem_busy(mem_busy),
    .pc(pc4), .exec_en(exec_en4), .halted(halted4), .done(done4),
    .fault(fault4), .cycle_cnt(cycle4), .instr_cnt(instr4)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] a);
    init_pc = a;
    start   = 1'b1;
    step();
    start   = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step();
    step();
    n_tests++; if (pc !== 16'd0) begin n_fail++; $display("FAIL por_pc got %0d want 0", pc); end
    n_tests++; if ({exec_en, halted, done, fault} !== 4'b0) begin n_fail++; $display("FAIL por_flags got %b want 0000", {exec_en, halted, done, fault}); end
    n_tests++; if ({cycle_cnt, instr_cnt} !== 32'd0) begin n_fail++; $display("FAIL por_cnt got %0d/%0d want 0/0", cycle_cnt, instr_cnt); end
    reset = 1'b0;
    step();
    do_start(16'd0);
    for (int i = 0; i < 5; i++) step();
    n_tests++; if (pc !== 16'd5) begin n_fail++; $display("FAIL mid_pc got %0d want 5", pc); end
    n_tests++; if (exec_en !== 1'b1) begin n_fail++; $display("FAIL mid_exec got %b want 1", exec_en); end
    #2;
    reset = 1'b1;
    #1;
    n_tests++; if (pc !== 16'd0) begin n_fail++; $display("FAIL async_pc got %0d want 0", pc); end
    n_tests++; if ({exec_en, halted, done, fault} !== 4'b0) begin n_fail++; $display("FAIL async_flags got %b want 0000", {exec_en, halted, done, fault}); end
    n_tests++; if ({cycle_cnt, instr_cnt} !== 32'd0) begin n_fail++; $display("FAIL async_cnt got %0d/%0d want 0/0", cycle_cnt, instr_cnt); end
    step();
    reset = 1'b0;
    step();
    n_tests++; if (pc !== 16'd0 || exec_en !== 1'b0) begin n_fail++; $display("FAIL idle_hold got pc=%0d ex=%b want 0/0", pc, exec_en); end
  endtask

  task automatic test_straight;
    rom_op[0] = OP_ADD;
    rom_op[1] = OP_LIM;
    rom_op[2] = OP_ADD;
    rom_op[3] = OP_HALT;
    do_start(16'd0);
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (pc !== 16'(i) || done !== 1'b0 || exec_en !== 1'b1) begin n_fail++; $display("FAIL seq_pc%0d got pc=%0d done=%b ex=%b want %0d/0/1", i, pc, done, exec_en, i); end
      step();
    end
    n_tests++; if (pc !== 16'd3 || done !== 1'b1) begin n_fail++; $display("FAIL halt_done got pc=%0d done=%b want 3/1", pc, done); end
    step();
    n_tests++; if (halted !== 1'b1 || done !== 1'b0 || exec_en !== 1'b0) begin n_fail++; $display("FAIL halt_state got h=%b d=%b ex=%b want 1/0/0", halted, done, exec_en); end
    n_tests++; if (pc !== 16'd3) begin n_fail++; $display("FAIL halt_pc got %0d want 3", pc); end
    n_tests++; if (instr_cnt !== 16'd4 || cycle_cnt !== 16'd4) begin n_fail++; $display("FAIL halt_cnt got %0d/%0d want 4/4", instr_cnt, cycle_cnt); end
    step();
    n_tests++; if (pc !== 16'd3 || cycle_cnt !== 16'd4 || halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold got pc=%0d cyc=%0d h=%b want 3/4/1", pc, cycle_cnt, halted); end
  endtask

  task automatic branch_case(input logic [3:0] op, input logic eq,
                             input logic lt, input logic [15:0] exp);
    rom_op[10] = op;
    rom_jl[10] = 16'd20;
    rom_op[11] = OP_HALT;
    rom_op[20] = OP_HALT;
    eq_flag = eq;
    lt_flag = lt;
    do_start(16'd10);
    step();
    n_tests++; if (pc !== exp) begin n_fail++; $display("FAIL br_op%0h_eq%b_lt%b got %0d want %0d", op, eq, lt, pc, exp); end
    step();
    n_tests++; if (halted !== 1'b1 || instr_cnt !== 16'd2) begin n_fail++; $display("FAIL br_end_op%0h got h=%b ic=%0d want 1/2", op, halted, instr_cnt); end
    eq_flag = 1'b0;
    lt_flag = 1'b0;
  endtask

  task automatic test_branches;
    branch_case(OP_BEQ, 1'b1, 1'b0, 16'd20);
    branch_case(OP_BEQ, 1'b0, 1'b0, 16'd11);
    branch_case(OP_BNE, 1'b0, 1'b0, 16'd20);
    branch_case(OP_BNE, 1'b1, 1'b0, 16'd11);
    branch_case(OP_BLT, 1'b0, 1'b1, 16'd20);
    branch_case(OP_BLT, 1'b1, 1'b0, 16'd11);
    branch_case(OP_JMP, 1'b0, 1'b0, 16'd20);
  endtask

  task automatic test_mem_stall;
    rom_op[7] = OP_LB;
    rom_op[8] = OP_HALT;
    mem_busy = 1'b1;
    do_start(16'd7);
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (pc !== 16'd7 || exec_en !== 1'b0) begin n_fail++; $display("FAIL stall%0d got pc=%0d ex=%b want 7/0", i, pc, exec_en); end
      step();
    end
    mem_busy = 1'b0;
    #1;
    n_tests++; if (pc !== 16'd7 || exec_en !== 1'b1) begin n_fail++; $display("FAIL stall_rel got pc=%0d ex=%b want 7/1", pc, exec_en); end
    step();
    n_tests++; if (pc !== 16'd8) begin n_fail++; $display("FAIL stall_next got %0d want 8", pc); end
    n_tests++; if (instr_cnt !== 16'd1 || cycle_cnt !== 16'd4) begin n_fail++; $display("FAIL stall_cnt got %0d/%0d want 1/4", instr_cnt, cycle_cnt); end
    step();
  endtask

  task automatic test_illegal;
    rom_op[9] = OP_TBA;
    do_start(16'd9);
    n_tests++; if (exec_en !== 1'b0) begin n_fail++; $display("FAIL ill_exec got %b want 0", exec_en); end
    step();
    n_tests++; if (fault !== 1'b1 || halted !== 1'b1 || pc !== 16'd9) begin n_fail++; $display("FAIL ill_state got f=%b h=%b pc=%0d want 1/1/9", fault, halted, pc); end
    n_tests++; if (instr_cnt !== 16'd0 || cycle_cnt !== 16'd1) begin n_fail++; $display("FAIL ill_cnt got %0d/%0d want 0/1", instr_cnt, cycle_cnt); end
    step();
    n_tests++; if (fault !== 1'b1) begin n_fail++; $display("FAIL ill_sticky got %b want 1", fault); end
    do_start(16'd2);
    n_tests++; if (fault !== 1'b0 || halted !== 1'b0 || pc !== 16'd2) begin n_fail++; $display("FAIL ill_restart got f=%b h=%b pc=%0d want 0/0/2", fault, halted, pc); end
    step();
    step();
  endtask

  task automatic test_overflow;
    rom_op[127] = OP_ADD;
    do_start(16'd127);
    n_tests++; if (exec_en !== 1'b1) begin n_fail++; $display("FAIL ovf_exec got %b want 1", exec_en); end
    step();
    n_tests++; if (fault !== 1'b1 || halted !== 1'b1 || pc !== 16'd127) begin n_fail++; $display("FAIL ovf_state got f=%b h=%b pc=%0d want 1/1/127", fault, halted, pc); end
    n_tests++; if (instr_cnt !== 16'd1) begin n_fail++; $display("FAIL ovf_retire got %0d want 1", instr_cnt); end
    rom_op[50] = OP_JMP;
    rom_jl[50] = 16'd200;
    do_start(16'd50);
    step();
    n_tests++; if (fault !== 1'b1 || halted !== 1'b1 || pc !== 16'd50) begin n_fail++; $display("FAIL ovf_jmp got f=%b h=%b pc=%0d want 1/1/50", fault, halted, pc); end
  endtask

  task automatic test_saturate;
    rom_op[0] = OP_JMP;
    rom_jl[0] = 16'd0;
    do_start(16'd0);
    for (int i = 0; i < 10; i++) step();
    init_pc = 16'd5;
    start   = 1'b1;
    step();
    start   = 1'b0;
    #1;
    n_tests++; if (pc !== 16'd0 || halted !== 1'b0) begin n_fail++; $display("FAIL start_ign got pc=%0d h=%b want 0/0", pc, halted); end
    for (int i = 0; i < 9; i++) step();
    n_tests++; if (cycle_cnt !== 16'd20 || instr_cnt !== 16'd20) begin n_fail++; $display("FAIL loop_cnt got %0d/%0d want 20/20", cycle_cnt, instr_cnt); end
    n_tests++; if (cycle4 !== 4'd15 || instr4 !== 4'd15) begin n_fail++; $display("FAIL sat_cnt got %0d/%0d want 15/15", cycle4, instr4); end
    n_tests++; if (pc4 !== 16'd0 || exec_en4 !== 1'b1 || {halted4, done4, fault4} !== 3'b0) begin n_fail++; $display("FAIL sat_state got pc=%0d ex=%b hdf=%b want 0/1/000", pc4, exec_en4, {halted4, done4, fault4}); end
    step();
    n_tests++; if (cycle4 !== 4'd15) begin n_fail++; $display("FAIL sat_hold got %0d want 15", cycle4); end
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    start    = 1'b0;
    init_pc  = 16'd0;
    eq_flag  = 1'b0;
    lt_flag  = 1'b0;
    mem_busy = 1'b0;
    for (int i = 0; i < 128; i++) begin
      rom_op[i] = OP_ADD;
      rom_jl[i] = 16'd0;
    end
    test_reset();
    test_straight();
    test_branches();
    test_mem_stall();
    test_illegal();
    test_overflow();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
